// File: rtl/uart_frame_assembler_if.sv
// uart_frame_assembler_if
//   Groups the byte-level receive signals and the frame-level results of the
//   UART frame assembler into one bundle.
//   master modport : the side that supplies received bytes and acknowledges frames
//   slave modport  : the frame assembler itself
//   Signals:
//     rxByte       received byte, valid only while rxStrobe is high
//     rxStrobe     one-cycle pulse marking a new byte
//     rxError      one-cycle pulse marking a byte-level framing error
//     clearDR      consumer acknowledge that releases the held frame
//     inputData    assembled frame, first byte in the most significant position
//     dataReceived frame-valid flag
//     overrun      sticky: a byte arrived while a frame was held
//     frameError   sticky: a partial frame was discarded
interface uart_frame_assembler_if #(
  parameter int BYTES = 6
);
  logic [7:0]         rxByte;
  logic               rxStrobe;
  logic               rxError;
  logic               clearDR;
  logic [8*BYTES-1:0] inputData;
  logic               dataReceived;
  logic               overrun;
  logic               frameError;

  modport master (
    output rxByte, rxStrobe, rxError, clearDR,
    input  inputData, dataReceived, overrun, frameError
  );

  modport slave (
    input  rxByte, rxStrobe, rxError, clearDR,
    output inputData, dataReceived, overrun, frameError
  );
endinterface

// File: rtl/uart_frame_assembler.sv
// uart_frame_assembler
//   Collects BYTES consecutive UART bytes into one big-endian frame and holds
//   it until the consumer acknowledges. A gap longer than TIMEOUT cycles or a
//   byte-level framing error discards a partial frame and raises frameError.
//   Parameters:
//     BYTES   bytes per frame (1..16)
//     TIMEOUT maximum inter-byte gap in masterClock cycles
//   Ports:
//     masterClock  single clock, rising edge
//     reset        synchronous, active-high reset
//     bus          uart_frame_assembler_if slave modport (byte input, frame output)
module uart_frame_assembler #(
  parameter int BYTES   = 6,
  parameter int TIMEOUT = 2600
) (
  input  logic                   masterClock,
  input  logic                   reset,
  uart_frame_assembler_if.slave  bus
);

  localparam int CW = $clog2(BYTES + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t             r_state;
  logic [CW-1:0]      r_count;
  logic [TW-1:0]      r_timer;
  logic [8*BYTES-1:0] r_data;
  logic               r_dataReceived;
  logic               r_overrun;
  logic               r_frameError;

  logic          w_lastByte;
  logic          w_gapExpired;
  logic          w_store;
  logic [CW-1:0] w_slot;

  assign w_lastByte   = (r_count == CW'(BYTES - 1));
  assign w_gapExpired = (r_timer == TW'(TIMEOUT - 1));

  // A byte is written into the frame register when it is accepted: in IDLE or
  // COLLECT unless rxError wins, or in HOLD only when the same cycle releases
  // the held frame, in which case it becomes byte 1 of the next frame.
  assign w_store = bus.rxStrobe &
                   ((r_state != HOLD) ? ~bus.rxError : bus.clearDR);
  assign w_slot  = (r_state == HOLD) ? '0 : r_count;

  // Single-process FSM with all outputs registered. Untouched frame bytes keep
  // stale content; only dataReceived qualifies inputData.
  always_ff @(posedge masterClock) begin
    if (reset) begin
      r_state        <= IDLE;
      r_count        <= '0;
      r_timer        <= '0;
      r_data         <= '0;
      r_dataReceived <= 1'b0;
      r_overrun      <= 1'b0;
      r_frameError   <= 1'b0;
    end else begin
      if (w_store) begin
        for (int i = 0; i < BYTES; i++) begin
          if (w_slot == CW'(i)) begin
            r_data[8*(BYTES-1-i) +: 8] <= bus.rxByte;
          end
        end
      end

      case (r_state)
        IDLE: begin
          if (bus.clearDR) begin
            r_overrun    <= 1'b0;
            r_frameError <= 1'b0;
          end
          if (bus.rxError) begin
            r_frameError <= 1'b1;
          end else if (bus.rxStrobe) begin
            r_count <= CW'(1);
            r_timer <= '0;
            if (BYTES == 1) begin
              r_state        <= HOLD;
              r_dataReceived <= 1'b1;
            end else begin
              r_state <= COLLECT;
            end
          end
        end

        COLLECT: begin
          if (bus.clearDR) begin
            r_overrun    <= 1'b0;
            r_frameError <= 1'b0;
          end
          // Discard sets frameError after the clear above, so a discard in the
          // same cycle as an acknowledge still leaves the error visible.
          if (bus.rxError || (!bus.rxStrobe && w_gapExpired)) begin
            r_frameError <= 1'b1;
            r_state      <= IDLE;
            r_count      <= '0;
            r_timer      <= '0;
          end else if (bus.rxStrobe) begin
            r_timer <= '0;
            r_count <= r_count + 1'b1;
            if (w_lastByte) begin
              r_state        <= HOLD;
              r_dataReceived <= 1'b1;
            end
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end

        HOLD: begin
          if (bus.clearDR) begin
            r_dataReceived <= 1'b0;
            r_overrun      <= 1'b0;
            r_frameError   <= 1'b0;
            if (bus.rxStrobe) begin
              r_count <= CW'(1);
              r_timer <= '0;
              if (BYTES == 1) begin
                r_state        <= HOLD;
                r_dataReceived <= 1'b1;
              end else begin
                r_state <= COLLECT;
              end
            end else begin
              r_state <= IDLE;
              r_count <= '0;
              r_timer <= '0;
            end
          end else if (bus.rxStrobe) begin
            r_overrun <= 1'b1;
          end
        end

        default: begin
          r_state <= IDLE;
          r_count <= '0;
          r_timer <= '0;
        end
      endcase
    end
  end

  assign bus.inputData    = r_data;
  assign bus.dataReceived = r_dataReceived;
  assign bus.overrun      = r_overrun;
  assign bus.frameError   = r_frameError;

endmodule
